// File: rtl/phy_behav_multi.sv
// Behavioural multi-PHY management model: NUM_PHYS 32x16 register files behind a
// ready/valid command port with fixed busy latency. Optional PHY_BEHAV_LINK_EN adds link_up.
module phy_behav_multi #(
  parameter int NUM_PHYS = 4,
  parameter int PHY_BASE = 0,
  parameter int LATENCY  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_read,
  input  logic [4:0]          cmd_phy,
  input  logic [4:0]          cmd_reg,
  input  logic [15:0]         cmd_wdata,
  output logic                busy,
  output logic                ack,
  output logic                err,
  output logic [15:0]         rdata
`ifdef PHY_BEHAV_LINK_EN
  ,
  input  logic [NUM_PHYS-1:0] link_up
`endif
);

  localparam int          IDX_W = (NUM_PHYS > 1) ? $clog2(NUM_PHYS) : 1;
  localparam int          CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [5:0]  BASE6 = 6'(PHY_BASE);
  localparam logic [5:0]  LIM6  = 6'(PHY_BASE + NUM_PHYS);
  localparam logic [4:0]  BASE5 = 5'(PHY_BASE);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

  function automatic logic [15:0] reg_default(input logic [4:0] a);
    case (a)
      5'd0:    return 16'h1140;
      5'd1:    return 16'h796D;
      5'd2:    return 16'h2215;
      5'd3:    return 16'h1430;
      default: return 16'h0000;
    endcase
  endfunction

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        regs [NUM_PHYS][32];
  logic               accept, hit, last_busy;
  logic [IDX_W-1:0]   idx, idx_q;
  logic [15:0]        rd_now, rd_q;
  logic               read_q, hit_q, soft_q;

  assign accept    = cmd_valid && (state == S_IDLE);
  assign hit       = ({1'b0, cmd_phy} >= BASE6) && ({1'b0, cmd_phy} < LIM6);
  assign idx       = IDX_W'(cmd_phy - BASE5);
  assign last_busy = (state == S_BUSY) && (cnt == '0);

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state == S_BUSY);
  assign ack       = (state == S_ACK);
  assign err       = (state == S_ACK) && !hit_q;

`ifdef PHY_BEHAV_LINK_EN
  logic [NUM_PHYS-1:0] link_latch;
  logic                reload_q;

  // Latched-low link status; a read of r1 re-arms the latch on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      link_latch <= link_up;
      reload_q   <= 1'b0;
    end else begin
      reload_q <= accept && hit && cmd_read && (cmd_reg == 5'd1);
      for (int i = 0; i < NUM_PHYS; i++) begin
        if (reload_q && (idx_q == IDX_W'(i))) link_latch[i] <= link_up[i];
        else                                   link_latch[i] <= link_latch[i] & link_up[i];
      end
    end
  end
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_now = regs[idx][cmd_reg];
`ifdef PHY_BEHAV_LINK_EN
    if (cmd_reg == 5'd1) rd_now[2] = link_latch[idx];
`endif
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_d = S_BUSY;
      S_BUSY:  if (cnt == '0) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      read_q <= 1'b0;
      hit_q  <= 1'b0;
      idx_q  <= '0;
      soft_q <= 1'b0;
      rd_q   <= '0;
      rdata  <= '0;
    end else begin
      if (accept) begin
        cnt    <= CNT_W'(LATENCY - 1);
        read_q <= cmd_read;
        hit_q  <= hit;
        idx_q  <= idx;
        soft_q <= hit && !cmd_read && (cmd_reg == 5'd0) && cmd_wdata[15];
        rd_q   <= rd_now;
      end else if ((state == S_BUSY) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      // Read data is published together with ack; writes never disturb it.
      if (last_busy && read_q) rdata <= hit_q ? rd_q : 16'hFFFF;
    end
  end

  // NOTE: the register files are reset explicitly because PHY defaults are architectural state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PHYS; p++)
        for (int r = 0; r < 32; r++)
          regs[IDX_W'(p)][5'(r)] <= reg_default(5'(r));
    end else begin
      if (accept && hit && !cmd_read && ((cmd_reg == 5'd0) || (cmd_reg > 5'd3)))
        regs[idx][cmd_reg] <= (cmd_reg == 5'd0) ? (cmd_wdata & 16'h7FFF) : cmd_wdata;
      if ((state == S_ACK) && soft_q)
        for (int r = 0; r < 32; r++)
          regs[idx_q][5'(r)] <= reg_default(5'(r));
    end
  end

endmodule
